conv_window_gen: RTL and testbench
==================================

# conv_window_gen

Streaming 3×3 sliding-window generator that sits directly upstream of `conv_kernal`. It accepts an ifmap one FP16 pixel per cycle in raster order, buffers the two previous rows, and emits one 9-element window per valid output position (no padding). Windows are presented in exactly the element order `conv_kernal` consumes, so its `window` input connects directly to `win_data`. A valid/ready handshake on both sides lets the kernel stall the stream.

## Interface
- `IMG_W`, default 4: ifmap width in pixels; must be ≥ 3.
- `IMG_H`, default 4: ifmap height in pixels; must be ≥ 3.
- `DW`, default 16: pixel width in bits (FP16, treated as opaque bits).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `pix_valid`  in  1  `pix_data` is valid.
- `pix_data`  in  DW  ifmap pixel, raster order (row-major, top-left first).
- `pix_ready`  out  1  pixel accepted when `pix_valid && pix_ready`.
- `win_valid`  out  1  `win_data` holds a complete window.
- `win_data`  out  9×DW  packed window `[8:0][DW-1:0]`; element `3*r+c` holds the pixel at window row r (0 = top), column c (0 = left).
- `win_last`  out  1  qualifies the final window of a frame.
- `win_ready`  in  1  downstream accepts the window when `win_valid && win_ready`.
- `frame_done`  out  1  single-cycle pulse when the last pixel of a frame is accepted.

## Operation
- Counters: `col` counts 0..IMG_W-1 and `row` counts 0..IMG_H-1. Both advance only on an accepted pixel. `col` wraps to 0 and increments `row`. Both wrap to 0 after pixel (IMG_H-1, IMG_W-1), and the next frame starts with no gap.
- Line buffers: lb0 holds the previous row and lb1 the row before it, each IMG_W deep. When pixel p is accepted at column `col`:
  - new column = {lb1[col], lb0[col], p}, ordered top to bottom;
  - lb1[col] ← lb0[col];
  - lb0[col] ← p.
- Shift window: a 3×3 register shifts left by one column and loads the new column into column 2.
- Emit rule: a window is produced when the accepted pixel has `row` ≥ 2 and `col` ≥ 2. The output register then loads the shifted window contents.
  - `win_last` = 1 iff that pixel is (IMG_H-1, IMG_W-1).
- Output order per frame: (0,0), (0,1) … (0,IMG_W-3), (1,0) …; (IMG_H-2)·(IMG_W-2) windows in total.
- Flow control:
  - `pix_ready = !win_valid || win_ready`.
  - `win_valid` sets on an emitting acceptance.
  - `win_valid` clears on a handshake with no new emitting acceptance in the same cycle.
  - Simultaneous drain and refill keeps `win_valid` high and loads the new window.
- Stale line-buffer and shift-register contents are never exposed: the emit rule guarantees every window element was written during the current frame.

## Timing
- Reset values: `win_valid`=0, `win_last`=0, `frame_done`=0, `win_data`=0, `row`=`col`=0. `pix_ready` is 1 out of reset. Line-buffer RAM contents are unspecified (not cleared).
- Latency: a window appears on `win_valid` the cycle after its completing pixel is accepted.
- Throughput: one pixel per cycle when `win_ready` stays high.
- `win_data` and `win_last` stay stable while `win_valid && !win_ready`.
- `frame_done` asserts the cycle after the last-pixel acceptance.
- Reset mid-frame: the frame is abandoned, no window is emitted, and the next accepted pixel is treated as (0,0).
- `pix_valid` low: no state changes; `win_valid` holds.

## Configuration
- `CONV_WIN_STRIDE2_EN`:
  - Defined: adds input port `stride2` (1 bit, held constant within a frame). When `stride2`=1, only windows with (row-2) even and (col-2) even are emitted. `win_last` marks the last emitted window, which may come before the frame's last pixel; `frame_done` is unchanged.
  - Undefined: no `stride2` port; stride is fixed at 1.

## Structure
- Shared `conv_pkg`:
  - `fp16_t` (logic [15:0]);
  - `win3x3_t` (`fp16_t [8:0]`);
  - localparam `KSIZE` = 3.
- Sub-module `conv_line_buf`: single-port row buffer of depth IMG_W with read-then-write at one address per accepted pixel; instantiated twice or as one 2×DW-wide instance.
- Top level holds the counters, the shift window, the output register and the handshake logic.

## Test plan
- 4×4 frame, pixel k carries raw value k+1, `win_ready`=1: expect 4 windows:
  - {1,2,3,5,6,7,9,10,11};
  - {2,3,4,6,7,8,10,11,12};
  - {5,6,7,9,10,11,13,14,15};
  - {6,7,8,10,11,12,14,15,16}, with `win_last` on this window only.
  - The first window is valid exactly one cycle after pixel 11 is accepted.
- Same frame with `win_ready` held low for 3 cycles while window 1 is pending: `pix_ready`=0, window 1 stable, no pixel lost; output identical to the first scenario.
- Two back-to-back 4×4 frames with distinct values: the second frame's windows contain no first-frame pixels, and `frame_done` pulses twice.
- `rst_n` asserted after 6 pixels, then a full frame: exactly 4 correct windows, none from the aborted data.
- IMG_W=5, IMG_H=3, random `pix_valid` gaps: 3 windows in order (0,0), (0,1), (0,2), matching a reference model.
- `CONV_WIN_STRIDE2_EN` defined, `stride2`=1, 6×6 frame: windows (0,0), (0,2), (2,0), (2,2) only; `win_last` on (2,2).

Source files
------------

// File: rtl/conv_pkg.sv
// Purpose: shared types and constants for the convolution datapath blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package conv_pkg;

    // Kernel edge length; the window generator and kernel agree on 3x3.
    localparam int KSIZE = 3;

    typedef logic [15:0] fp16_t;

    // Window element 3*r+c holds row r (0 = top), column c (0 = left).
    typedef fp16_t [8:0] win3x3_t;

endpackage

// File: rtl/conv_line_buf.sv
// Purpose: single-port row buffer, combinational read then write at the same address.
// Latency: read data valid the same cycle as addr; the write lands on the rising edge.
// Backpressure: none; the caller gates we with its own accept condition.
module conv_line_buf #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    // Contents are not reset: every word is rewritten before it is consumed.
    logic [WIDTH-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    // Write the new word after the old one has been read this cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Purpose: streaming 3x3 window generator (no padding) feeding conv_kernal; optional CONV_WIN_STRIDE2_EN adds a stride2 port.
// Latency: a window is valid the cycle after its completing pixel is accepted.
// Backpressure: pix_ready = !win_valid || win_ready, so a stalled window holds the pixel stream.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int IMG_W = 4,
    parameter int IMG_H = 4,
    parameter int DW    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef CONV_WIN_STRIDE2_EN
    input  logic                 stride2,
`endif
    input  logic                 pix_valid,
    input  logic [DW-1:0]        pix_data,
    output logic                 pix_ready,
    output logic                 win_valid,
    output logic [8:0][DW-1:0]   win_data,
    output logic                 win_last,
    input  logic                 win_ready,
    output logic                 frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_MAX  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_H - 1);
    // First row/column at which a full kernel footprint has been seen.
    localparam logic [CW-1:0] COL_EDGE = CW'(KSIZE - 1);
    localparam logic [RW-1:0] ROW_EDGE = RW'(KSIZE - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    logic pix_acc;
    logic frame_end;
    logic emit;
    logic emit_last;

    // Line buffer word = {row before previous, previous row} at this column.
    logic [2*DW-1:0] lb_rd;
    logic [2*DW-1:0] lb_wr;

    // Newest column of the window, index 0 = top.
    logic [KSIZE-1:0][DW-1:0] new_col;

    // Two most recent columns; the third is the incoming new_col, so the
    // oldest column of a shifted 3x3 register never needs to be stored.
    logic [KSIZE-1:0][KSIZE-2:0][DW-1:0] hist;

    logic [8:0][DW-1:0] win_next;

    assign pix_ready = !win_valid || win_ready;
    assign pix_acc   = pix_valid && pix_ready;
    assign frame_end = (row == ROW_MAX) && (col == COL_MAX);

    assign lb_wr   = {lb_rd[DW-1:0], pix_data};
    assign new_col = {pix_data, lb_rd[DW-1:0], lb_rd[2*DW-1:DW]};

    conv_line_buf #(
        .DEPTH (IMG_W),
        .WIDTH (2 * DW),
        .AW    (CW)
    ) u_line_buf (
        .clk     (clk),
        .we      (pix_acc),
        .addr    (col),
        .wr_data (lb_wr),
        .rd_data (lb_rd)
    );

`ifdef CONV_WIN_STRIDE2_EN
    // Last emitted position under stride 2: largest even offset from the edge.
    localparam logic [CW-1:0] COL_LAST2 = CW'(((IMG_W - 1) % 2 == 0) ? IMG_W - 1 : IMG_W - 2);
    localparam logic [RW-1:0] ROW_LAST2 = RW'(((IMG_H - 1) % 2 == 0) ? IMG_H - 1 : IMG_H - 2);

    logic stride_ok;
    // (row-2) and (col-2) even reduce to row and col even.
    assign stride_ok = !stride2 || (!row[0] && !col[0]);
    assign emit_last = stride2 ? ((row == ROW_LAST2) && (col == COL_LAST2)) : frame_end;
`else
    logic stride_ok;
    assign stride_ok = 1'b1;
    assign emit_last = frame_end;
`endif

    assign emit = pix_acc && (row >= ROW_EDGE) && (col >= COL_EDGE) && stride_ok;

    // Assemble the window as it will look after this pixel shifts in.
    always_comb begin
        win_next = '0;
        for (int r = 0; r < KSIZE; r++) begin
            win_next[KSIZE*r + 0] = hist[r][0];
            win_next[KSIZE*r + 1] = hist[r][1];
            win_next[KSIZE*r + 2] = new_col[r];
        end
    end

    // Shift the column history left on every accepted pixel.
    always_ff @(posedge clk) begin
        if (pix_acc) begin
            for (int r = 0; r < KSIZE; r++) begin
                hist[r][0] <= hist[r][1];
                hist[r][1] <= new_col[r];
            end
        end
    end

    // Raster position of the next pixel; wraps at end of frame with no gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (pix_acc) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Output register: load on emit, drop valid once the window is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid <= 1'b0;
            win_data  <= '0;
            win_last  <= 1'b0;
        end else if (emit) begin
            win_valid <= 1'b1;
            win_data  <= win_next;
            win_last  <= emit_last;
        end else if (win_ready) begin
            win_valid <= 1'b0;
        end
    end

    // One-cycle pulse after the final pixel of a frame is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= pix_acc && frame_end;
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Purpose: directed, table-driven bench for conv_window_gen (4x4 and 5x3 instances, 6x6 stride-2 when CONV_WIN_STRIDE2_EN).
// Latency: expects a window one cycle after its completing pixel is accepted.
// Backpressure: exercises a held window with win_ready low while pixels are offered.
module tb_conv_window_gen;

    typedef logic [8:0][15:0] win_t;

    typedef struct {
        logic [15:0] pix;
        logic        vld;
        win_t        win;
        logic        last;
        logic        fd;
    } vec_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        pix_valid, pix_ready, win_valid, win_last, win_ready, frame_done;
    logic [15:0] pix_data;
    win_t        win_data;

    logic        p5_valid, p5_ready, w5_valid, w5_last, w5_ready, fd5;
    logic [15:0] p5_data;
    win_t        w5_data;

    int checks   = 0;
    int failures = 0;

    win_t got_w[$];
    logic got_l[$];
    win_t exp_w[$];
    logic exp_l[$];
    int   fd_cnt;

    win_t g5_w[$];
    logic g5_l[$];
    int   fd5_cnt;

    vec_t tv[16];

    conv_window_gen #(.IMG_W(4), .IMG_H(4), .DW(16)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef CONV_WIN_STRIDE2_EN
        .stride2    (1'b0),
`endif
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_ready  (pix_ready),
        .win_valid  (win_valid),
        .win_data   (win_data),
        .win_last   (win_last),
        .win_ready  (win_ready),
        .frame_done (frame_done)
    );

    conv_window_gen #(.IMG_W(5), .IMG_H(3), .DW(16)) u_dut5 (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef CONV_WIN_STRIDE2_EN
        .stride2    (1'b0),
`endif
        .pix_valid  (p5_valid),
        .pix_data   (p5_data),
        .pix_ready  (p5_ready),
        .win_valid  (w5_valid),
        .win_data   (w5_data),
        .win_last   (w5_last),
        .win_ready  (w5_ready),
        .frame_done (fd5)
    );

`ifdef CONV_WIN_STRIDE2_EN
    logic        p6_valid, p6_ready, w6_valid, w6_last, w6_ready, fd6;
    logic [15:0] p6_data;
    win_t        w6_data;
    win_t        g6_w[$];
    logic        g6_l[$];

    conv_window_gen #(.IMG_W(6), .IMG_H(6), .DW(16)) u_dut6 (
        .clk        (clk),
        .rst_n      (rst_n),
        .stride2    (1'b1),
        .pix_valid  (p6_valid),
        .pix_data   (p6_data),
        .pix_ready  (p6_ready),
        .win_valid  (w6_valid),
        .win_data   (w6_data),
        .win_last   (w6_last),
        .win_ready  (w6_ready),
        .frame_done (fd6)
    );

    // Record every window handshake of the stride-2 instance.
    always @(negedge clk) begin
        #2;
        if (w6_valid && w6_ready) begin
            g6_w.push_back(w6_data);
            g6_l.push_back(w6_last);
        end
    end
`endif

    // Record every window handshake and frame_done pulse of the 4x4 instance.
    always @(negedge clk) begin
        #2;
        if (win_valid && win_ready) begin
            got_w.push_back(win_data);
            got_l.push_back(win_last);
        end
        if (frame_done) fd_cnt++;
    end

    // Same for the 5x3 instance.
    always @(negedge clk) begin
        #2;
        if (w5_valid && w5_ready) begin
            g5_w.push_back(w5_data);
            g5_l.push_back(w5_last);
        end
        if (fd5) fd5_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [143:0] act, input logic [143:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic win_t mkwin(input int a0, input int a1, input int a2,
                                   input int a3, input int a4, input int a5,
                                   input int a6, input int a7, input int a8);
        win_t w;
        w[0] = 16'(a0); w[1] = 16'(a1); w[2] = 16'(a2);
        w[3] = 16'(a3); w[4] = 16'(a4); w[5] = 16'(a5);
        w[6] = 16'(a6); w[7] = 16'(a7); w[8] = 16'(a8);
        return w;
    endfunction

    // Reference window with top-left pixel (r,c); pixel k of the frame = base + k.
    function automatic win_t model(input int base, input int w, input int r, input int c);
        win_t m;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                m[3*i + j] = 16'(base + (r + i) * w + c + j);
        return m;
    endfunction

    task automatic send(input logic [15:0] d);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            pix_valid = 1'b1;
            pix_data  = d;
            #1;
            if (pix_ready) begin
                @(posedge clk);
                break;
            end
            n++;
            if (n > 50) begin
                checks++;
                failures++;
                $display("FAIL send_timeout actual=pix_ready_low required=accept data=%0d", d);
                break;
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic clear_q();
        got_w.delete(); got_l.delete();
        exp_w.delete(); exp_l.delete();
        fd_cnt = 0;
    endtask

    task automatic compare_out(input string name);
        chk({name, "_count"}, 144'(got_w.size()), 144'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
            chk($sformatf("%s_win%0d", name, i), got_w[i], exp_w[i]);
            chk($sformatf("%s_last%0d", name, i), 144'(got_l[i]), 144'(exp_l[i]));
        end
    endtask

    initial begin
        // Vector table for a 4x4 frame with pixel k = k+1 and win_ready high.
        for (int k = 0; k < 16; k++)
            tv[k] = '{pix: 16'(k + 1), vld: 1'b0, win: '0, last: 1'b0, fd: 1'b0};
        tv[10].vld = 1'b1; tv[10].win = mkwin(1, 2, 3, 5, 6, 7, 9, 10, 11);
        tv[11].vld = 1'b1; tv[11].win = mkwin(2, 3, 4, 6, 7, 8, 10, 11, 12);
        tv[14].vld = 1'b1; tv[14].win = mkwin(5, 6, 7, 9, 10, 11, 13, 14, 15);
        tv[15].vld = 1'b1; tv[15].win = mkwin(6, 7, 8, 10, 11, 12, 14, 15, 16);
        tv[15].last = 1'b1; tv[15].fd = 1'b1;

        rst_n = 1'b1; pix_valid = 1'b0; pix_data = '0; win_ready = 1'b1;
        p5_valid = 1'b0; p5_data = '0; w5_ready = 1'b1;
`ifdef CONV_WIN_STRIDE2_EN
        p6_valid = 1'b0; p6_data = '0; w6_ready = 1'b1;
`endif
        fd_cnt = 0; fd5_cnt = 0;

        // Reset state.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_win_valid", 144'(win_valid), 144'(0));
        chk("rst_win_last", 144'(win_last), 144'(0));
        chk("rst_frame_done", 144'(frame_done), 144'(0));
        chk("rst_win_data", win_data, '0);
        chk("rst_pix_ready", 144'(pix_ready), 144'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Scenario 1: table applied pixel by pixel, outputs checked after each accept.
        clear_q();
        for (int k = 0; k < 16; k++) begin
            send(tv[k].pix);
            #1;
            chk($sformatf("s1_vld_%0d", k), 144'(win_valid), 144'(tv[k].vld));
            if (tv[k].vld) begin
                chk($sformatf("s1_data_%0d", k), win_data, tv[k].win);
                chk($sformatf("s1_last_%0d", k), 144'(win_last), 144'(tv[k].last));
            end
            chk($sformatf("s1_fd_%0d", k), 144'(frame_done), 144'(tv[k].fd));
        end
        idle();
        repeat (3) @(negedge clk);
        for (int k = 0; k < 16; k++)
            if (tv[k].vld) begin
                exp_w.push_back(tv[k].win);
                exp_l.push_back(tv[k].last);
            end
        compare_out("s1");

        // Scenario 2: stall window 1 for three cycles while pixel 12 is offered.
        clear_q();
        for (int k = 0; k < 11; k++) send(tv[k].pix);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            win_ready = 1'b0;
            pix_valid = 1'b1;
            pix_data  = tv[11].pix;
            #1;
            chk($sformatf("s2_pix_ready_%0d", s), 144'(pix_ready), 144'(0));
            chk($sformatf("s2_win_valid_%0d", s), 144'(win_valid), 144'(1));
            chk($sformatf("s2_win_hold_%0d", s), win_data, tv[10].win);
        end
        @(posedge clk);
        #1 win_ready = 1'b1;
        for (int k = 11; k < 16; k++) send(tv[k].pix);
        idle();
        repeat (3) @(negedge clk);
        for (int k = 0; k < 16; k++)
            if (tv[k].vld) begin
                exp_w.push_back(tv[k].win);
                exp_l.push_back(tv[k].last);
            end
        compare_out("s2");

        // Scenario 3: two back-to-back frames with distinct values.
        clear_q();
        for (int k = 0; k < 16; k++) send(16'(1 + k));
        for (int k = 0; k < 16; k++) send(16'(101 + k));
        idle();
        repeat (3) @(negedge clk);
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < 2; c++) begin
                    exp_w.push_back(model(f == 0 ? 1 : 101, 4, r, c));
                    exp_l.push_back(r == 1 && c == 1);
                end
        compare_out("s3");
        chk("s3_frame_done_pulses", 144'(fd_cnt), 144'(2));

        // Scenario 4: reset after 6 pixels, then a clean frame.
        clear_q();
        for (int k = 0; k < 6; k++) send(16'(201 + k));
        idle();
        rst_n = 1'b0;
        #1;
        chk("s4_rst_win_valid", 144'(win_valid), 144'(0));
        chk("s4_rst_pix_ready", 144'(pix_ready), 144'(1));
        @(negedge clk);
        rst_n = 1'b1;
        clear_q();
        for (int k = 0; k < 16; k++) send(16'(51 + k));
        idle();
        repeat (3) @(negedge clk);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                exp_w.push_back(model(51, 4, r, c));
                exp_l.push_back(r == 1 && c == 1);
            end
        compare_out("s4");
        chk("s4_frame_done_pulses", 144'(fd_cnt), 144'(1));

        // Scenario 5: 5x3 frame with random valid gaps.
        g5_w.delete(); g5_l.delete(); fd5_cnt = 0;
        begin
            int k, n;
            logic acc;
            k = 0; n = 0;
            while (k < 15 && n < 400) begin
                @(negedge clk);
                p5_valid = 1'($urandom_range(0, 1));
                p5_data  = 16'(k + 1);
                #1;
                acc = p5_valid && p5_ready;
                @(posedge clk);
                if (acc) k++;
                n++;
            end
            chk("s5_pixels_accepted", 144'(k), 144'(15));
        end
        @(negedge clk);
        p5_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("s5_count", 144'(g5_w.size()), 144'(3));
        for (int c = 0; c < 3 && c < g5_w.size(); c++) begin
            chk($sformatf("s5_win%0d", c), g5_w[c], model(1, 5, 0, c));
            chk($sformatf("s5_last%0d", c), 144'(g5_l[c]), 144'(c == 2));
        end
        chk("s5_frame_done_pulses", 144'(fd5_cnt), 144'(1));

`ifdef CONV_WIN_STRIDE2_EN
        // Scenario 6: 6x6 frame with stride 2.
        g6_w.delete(); g6_l.delete();
        for (int k = 0; k < 36; k++) begin
            @(negedge clk);
            p6_valid = 1'b1;
            p6_data  = 16'(k + 1);
            #1;
            if (!p6_ready) begin
                checks++;
                failures++;
                $display("FAIL s6_pix_ready actual=0 required=1 k=%0d", k);
            end
            @(posedge clk);
        end
        @(negedge clk);
        p6_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("s6_count", 144'(g6_w.size()), 144'(4));
        for (int i = 0; i < 4 && i < g6_w.size(); i++) begin
            chk($sformatf("s6_win%0d", i), g6_w[i], model(1, 6, (i / 2) * 2, (i % 2) * 2));
            chk($sformatf("s6_last%0d", i), 144'(g6_l[i]), 144'(i == 3));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
